// File: rtl/imm_pkg.sv
// Shared format codes and RV opcode constants for the immediate-generator stage.
package imm_pkg;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // funct3 001 (sll) and 101 (srl/sra) carry a shamt instead of a 12-bit immediate
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> extended immediate, format code, illegal flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_err
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic signed [31:0] w_v;
  logic [XLEN-1:0]    w_shamt;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] t;
    t = v;
    return t;
  endfunction

  always_comb begin
    o_fmt = FMT_ILL;
    o_err = 1'b1;
    unique case (w_opc)
      OPC_OPIMM:              begin o_fmt = is_shift(w_f3) ? FMT_SH : FMT_I; o_err = 1'b0; end
      OPC_LOAD, OPC_JALR:     begin o_fmt = FMT_I; o_err = 1'b0; end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          o_fmt = is_shift(w_f3) ? FMT_SH : FMT_I;
          o_err = 1'b0;
        end
      end
      OPC_STORE:              begin o_fmt = FMT_S; o_err = 1'b0; end
      OPC_BRANCH:             begin o_fmt = FMT_B; o_err = 1'b0; end
      OPC_LUI, OPC_AUIPC:     begin o_fmt = FMT_U; o_err = 1'b0; end
      OPC_JAL:                begin o_fmt = FMT_J; o_err = 1'b0; end
      OPC_OP:                 begin o_fmt = FMT_R; o_err = 1'b0; end
      OPC_OP32: begin
        if (XLEN == 64) begin
          o_fmt = FMT_R;
          o_err = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Every signed format is assembled as a 32-bit value, then widened to XLEN
  always_comb begin
    w_v = '0;
    unique case (o_fmt)
      FMT_I:   w_v = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   w_v = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   w_v = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      FMT_U:   w_v = {i_instr[31:12], 12'b0};
      FMT_J:   w_v = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: w_v = '0;
    endcase
  end

  always_comb begin
    w_shamt          = '0;
    w_shamt[SHW-1:0] = i_instr[20 +: SHW];
  end

  assign o_imm = (o_fmt == FMT_SH) ? w_shamt : sext32(w_v);

endmodule

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator: decoded result held behind a valid/ready output buffer.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            err_o
);

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_err;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_instr (instr_i),
    .o_imm   (w_dec_imm),
    .o_fmt   (w_dec_fmt),
    .o_err   (w_dec_err)
  );

  logic            r_main_vld;
  logic [XLEN-1:0] r_main_imm;
  logic [2:0]      r_main_fmt;
  logic            r_main_err;

  logic            w_acc;
  logic            w_main_free;
  logic            w_skid_vld;
  logic [XLEN-1:0] w_skid_imm;
  logic [2:0]      w_skid_fmt;
  logic            w_skid_err;

  assign w_acc       = in_valid_i & in_ready_o;
  assign w_main_free = ~r_main_vld | out_ready_i;

  generate
    if (SKID != 0) begin : g_skid
      logic            r_skid_vld;
      logic [XLEN-1:0] r_skid_imm;
      logic [2:0]      r_skid_fmt;
      logic            r_skid_err;

      // Skid only fills when main is full and not draining; it always empties into main
      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
          if (out_ready_i) r_skid_vld <= 1'b0;
        end else if (w_acc && !w_main_free) begin
          r_skid_vld <= 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!r_skid_vld && w_acc && !w_main_free) begin
          r_skid_imm <= w_dec_imm;
          r_skid_fmt <= w_dec_fmt;
          r_skid_err <= w_dec_err;
        end
      end

      assign in_ready_o = ~r_skid_vld;
      assign w_skid_vld = r_skid_vld;
      assign w_skid_imm = r_skid_imm;
      assign w_skid_fmt = r_skid_fmt;
      assign w_skid_err = r_skid_err;
    end else begin : g_noskid
      assign in_ready_o = w_main_free;
      assign w_skid_vld = 1'b0;
      assign w_skid_imm = '0;
      assign w_skid_fmt = '0;
      assign w_skid_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_main_vld <= 1'b0;
      r_main_imm <= '0;
      r_main_fmt <= '0;
      r_main_err <= 1'b0;
    end else if (flush_i) begin
      r_main_vld <= 1'b0;
    end else if (w_main_free) begin
      // The older skid entry has priority over a fresh decode
      if (w_skid_vld) begin
        r_main_vld <= 1'b1;
        r_main_imm <= w_skid_imm;
        r_main_fmt <= w_skid_fmt;
        r_main_err <= w_skid_err;
      end else if (w_acc) begin
        r_main_vld <= 1'b1;
        r_main_imm <= w_dec_imm;
        r_main_fmt <= w_dec_fmt;
        r_main_err <= w_dec_err;
      end else begin
        r_main_vld <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_main_vld;
  assign imm_o       = r_main_imm;
  assign fmt_o       = r_main_fmt;
  assign err_o       = r_main_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 with skid buffer and XLEN=64 without.
module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush32, iv32, ir32, ov32, or32, err32;
  logic [31:0] ins32, imm32;
  logic [2:0]  fmt32;
  logic        flush64, iv64, ir64, ov64, or64, err64;
  logic [31:0] ins64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int   errs   = 0;
  int   checks = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  imm_gen_stage #(.XLEN(32), .SKID(1)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush32), .instr_i(ins32),
    .in_valid_i(iv32), .in_ready_o(ir32), .out_valid_o(ov32), .out_ready_i(or32),
    .imm_o(imm32), .fmt_o(fmt32), .err_o(err32)
  );

  imm_gen_stage #(.XLEN(64), .SKID(0)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64), .instr_i(ins64),
    .in_valid_i(iv64), .in_ready_o(ir64), .out_valid_o(ov64), .out_ready_i(or64),
    .imm_o(imm64), .fmt_o(fmt64), .err_o(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins, input int xl);
    exp_t   r;
    longint si;
    longint v;
    si    = longint'($signed(ins));
    v     = 0;
    r.fmt = 3'd7;
    r.err = 1'b1;
    case (ins[6:0])
      7'h13, 7'h1B: begin
        if (!(ins[6:0] == 7'h1B && xl == 32)) begin
          r.err = 1'b0;
          if (ins[13:12] == 2'b01) begin
            r.fmt = 3'd6;
            v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
          end else begin
            r.fmt = 3'd1;
            v = si >>> 20;
          end
        end
      end
      7'h03, 7'h67: begin r.fmt = 3'd1; r.err = 1'b0; v = si >>> 20; end
      7'h23: begin
        r.fmt = 3'd2; r.err = 1'b0;
        v = ((si >>> 25) << 5) | longint'(ins[11:7]);
      end
      7'h63: begin
        r.fmt = 3'd3; r.err = 1'b0;
        v = ((si >>> 31) << 12) | (longint'(ins[7]) << 11) |
            (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin r.fmt = 3'd4; r.err = 1'b0; v = si & ~longint'(4095); end
      7'h6F: begin
        r.fmt = 3'd5; r.err = 1'b0;
        v = ((si >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
            (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      end
      7'h33: begin r.fmt = 3'd0; r.err = 1'b0; end
      7'h3B: if (xl == 64) begin r.fmt = 3'd0; r.err = 1'b0; end
      default: ;
    endcase
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    r.imm = v;
    return r;
  endfunction

  // Scoreboards: sample both handshakes mid-cycle, where inputs and outputs are stable
  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      q64.delete();
    end else begin
      if (ov32 && or32) begin
        if (q32.size() == 0) chk("sb32_unexpected", 1, 0);
        else begin
          e32 = q32.pop_front();
          chk("sb32_imm", {32'b0, imm32}, e32.imm);
          chk("sb32_fmt", fmt32, e32.fmt);
          chk("sb32_err", err32, e32.err);
        end
      end
      if (flush32) q32.delete();
      else if (iv32 && ir32) q32.push_back(ref_dec(ins32, 32));
      if (ov64 && or64) begin
        if (q64.size() == 0) chk("sb64_unexpected", 1, 0);
        else begin
          e64 = q64.pop_front();
          chk("sb64_imm", imm64, e64.imm);
          chk("sb64_fmt", fmt64, e64.fmt);
          chk("sb64_err", err64, e64.err);
        end
      end
      if (flush64) q64.delete();
      else if (iv64 && ir64) q64.push_back(ref_dec(ins64, 64));
    end
  end

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] ins, input logic [31:0] eimm,
                        input logic [2:0] efmt, input logic eerr);
    iv32 = 1'b1; ins32 = ins; or32 = 1'b1;
    mid(); adv();
    iv32 = 1'b0;
    mid();
    chk("d32_valid", ov32, 1);
    chk("d32_imm", imm32, eimm);
    chk("d32_fmt", fmt32, efmt);
    chk("d32_err", err32, eerr);
    adv();
  endtask

  task automatic send64(input logic [31:0] ins, input logic [63:0] eimm,
                        input logic [2:0] efmt, input logic eerr);
    iv64 = 1'b1; ins64 = ins; or64 = 1'b1;
    mid(); adv();
    iv64 = 1'b0;
    mid();
    chk("d64_valid", ov64, 1);
    chk("d64_imm", imm64, eimm);
    chk("d64_fmt", fmt64, efmt);
    chk("d64_err", err64, eerr);
    adv();
  endtask

  logic [6:0] opcs [14];

  initial begin
    opcs = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
             7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0F, 7'h73};
    rst = 1'b1;
    flush32 = 0; iv32 = 0; or32 = 0; ins32 = '0;
    flush64 = 0; iv64 = 0; or64 = 0; ins64 = '0;
    adv(); adv();
    mid();
    chk("rst_ov32", ov32, 0);
    chk("rst_imm32", imm32, 0);
    chk("rst_fmt32", fmt32, 0);
    chk("rst_err32", err32, 0);
    chk("rst_ov64", ov64, 0);
    chk("rst_imm64", imm64, 0);
    adv();
    rst = 1'b0;
    mid();
    chk("rst_rdy32", ir32, 1);
    chk("rst_rdy64", ir64, 1);
    adv();

    send32(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send32(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    send32(32'h41F0D093, 32'h0000001F, 3'd6, 1'b0);
    send32(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    send32(32'h0000007F, 32'h00000000, 3'd7, 1'b1);
    send32(32'h0000101B, 32'h00000000, 3'd7, 1'b1);
    send32(32'h800000EF, 32'hFFF00000, 3'd5, 1'b0);
    send64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send64(32'h03F09093, 64'h000000000000003F, 3'd6, 1'b0);
    send64(32'h4010101B, 64'h0000000000000001, 3'd6, 1'b0);
    send64(32'h0000003B, 64'h0, 3'd0, 1'b0);

    // Stall: A, B, C back to back with the consumer stalled for two cycles
    or32 = 1'b0; iv32 = 1'b1; ins32 = 32'hFFF00093;
    mid(); adv();
    ins32 = 32'hFE000EE3;
    mid();
    chk("stall_ov", ov32, 1);
    chk("stall_immA", imm32, 32'hFFFFFFFF);
    adv();
    ins32 = 32'h41F0D093;
    mid();
    chk("stall_rdy_full", ir32, 0);
    chk("stall_hold1", imm32, 32'hFFFFFFFF);
    adv();
    or32 = 1'b1;
    mid();
    chk("stall_rdy_still", ir32, 0);
    chk("stall_hold2", imm32, 32'hFFFFFFFF);
    adv();
    mid();
    chk("stall_rdy_back", ir32, 1);
    chk("stall_immB", imm32, 32'hFFFFFFFC);
    adv();
    iv32 = 1'b0;
    mid();
    chk("stall_immC", imm32, 32'h0000001F);
    adv();
    mid();
    chk("stall_empty", ov32, 0);
    adv();

    // Flush with both entries full and the source still presenting
    or32 = 1'b0; iv32 = 1'b1; ins32 = 32'hFFF00093;
    mid(); adv();
    ins32 = 32'h12345037;
    mid(); adv();
    ins32 = 32'h00500093; flush32 = 1'b1;
    mid(); adv();
    flush32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    mid();
    chk("flush_ov", ov32, 0);
    chk("flush_rdy", ir32, 1);
    adv();
    mid();
    chk("flush_gone", ov32, 0);
    adv();

    // Flush with room in the buffer: the accepted flush-cycle input is dropped
    or32 = 1'b0; iv32 = 1'b1; ins32 = 32'hFFF00093;
    mid(); adv();
    ins32 = 32'h00500093; flush32 = 1'b1;
    mid();
    chk("flush2_rdy", ir32, 1);
    adv();
    flush32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    mid();
    chk("flush2_ov", ov32, 0);
    adv();

    // Reset with both entries full
    or32 = 1'b0; iv32 = 1'b1; ins32 = 32'hFFF00093;
    mid(); adv();
    ins32 = 32'hFE000EE3;
    mid(); adv();
    rst = 1'b1; ins32 = 32'h00500093;
    mid(); adv();
    rst = 1'b0; iv32 = 1'b0;
    mid();
    chk("rst2_ov", ov32, 0);
    chk("rst2_imm", imm32, 0);
    chk("rst2_fmt", fmt32, 0);
    chk("rst2_err", err32, 0);
    chk("rst2_rdy", ir32, 1);
    adv();
    send32(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);

    // Random traffic through both instances, occasional flush on the skid instance
    for (int i = 0; i < 400; i++) begin
      iv32    = ($urandom_range(0, 3) != 0);
      or32    = ($urandom_range(0, 3) != 0);
      flush32 = ($urandom_range(0, 31) == 0);
      ins32   = $urandom;
      ins32[6:0] = opcs[$urandom_range(0, 13)];
      iv64    = ($urandom_range(0, 3) != 0);
      or64    = ($urandom_range(0, 3) != 0);
      ins64   = $urandom;
      ins64[6:0] = opcs[$urandom_range(0, 13)];
      mid(); adv();
    end
    iv32 = 1'b0; iv64 = 1'b0; flush32 = 1'b0; or32 = 1'b1; or64 = 1'b1;
    repeat (4) begin
      mid(); adv();
    end
    mid();
    chk("sb32_leftover", q32.size(), 0);
    chk("sb64_leftover", q64.size(), 0);
    chk("end_ov32", ov32, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
